// File: rtl/adivinha_4bits.sv
// Guessing-game controller around a 4-bit magnitude comparator: registers secret/guess, counts attempts, flags win/loss.
// Optional attempt limit (MAX_TENT) is enabled by defining ADIVINHA_LIMITE_EN.
module adivinha_4bits #(
   parameter int MAX_TENT = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       carrega,
   input  logic [3:0] segredo,
   input  logic       tenta,
   input  logic [3:0] palpite,
   output logic [3:0] X,
   output logic [3:0] Y,
   input  logic       igual,
   input  logic       maior,
   input  logic       menor,
   output logic       dica_maior,
   output logic       dica_menor,
   output logic       acertou,
   output logic       perdeu,
   output logic [3:0] tentativas,
   output logic [1:0] estado
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      ESPERA  = 2'b01,
      COMPARA = 2'b10,
      FIM     = 2'b11
   } estado_t;

   estado_t    state_r, next_state_s;
   logic [3:0] x_r, y_r, tent_r;
   logic       dm_r, dn_r, ac_r, pe_r;
   logic [3:0] x_nx_s, y_nx_s, tent_nx_s, tent_inc_s;
   logic       dm_nx_s, dn_nx_s, ac_nx_s, pe_nx_s;
   logic       limit_hit_s;

`ifdef ADIVINHA_LIMITE_EN
   assign limit_hit_s = (({1'b0, tent_r} + 5'd1) == 5'(MAX_TENT));
`else
   logic [3:0] unused_max_tent_s;
   assign unused_max_tent_s = 4'(MAX_TENT);
   assign limit_hit_s       = 1'b0;
`endif

   // The count never wraps; with the limit enabled it stops at MAX_TENT anyway.
   assign tent_inc_s = (tent_r == 4'hF) ? 4'hF : (tent_r + 4'd1);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= OCIOSO;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         OCIOSO: begin
            if (carrega) next_state_s = ESPERA;
            else         next_state_s = OCIOSO;
         end
         ESPERA: begin
            if (carrega)    next_state_s = ESPERA;
            else if (tenta) next_state_s = COMPARA;
            else            next_state_s = ESPERA;
         end
         COMPARA: begin
            if (igual || limit_hit_s) next_state_s = FIM;
            else                      next_state_s = ESPERA;
         end
         FIM: begin
            if (carrega) next_state_s = ESPERA;
            else         next_state_s = FIM;
         end
         default: next_state_s = OCIOSO;
      endcase
   end

   // Next values of the datapath and flag registers
   always_comb begin
      x_nx_s    = x_r;
      y_nx_s    = y_r;
      tent_nx_s = tent_r;
      dm_nx_s   = dm_r;
      dn_nx_s   = dn_r;
      ac_nx_s   = ac_r;
      pe_nx_s   = pe_r;
      case (state_r)
         OCIOSO, ESPERA, FIM: begin
            if (carrega) begin
               y_nx_s    = segredo;
               tent_nx_s = 4'd0;
               dm_nx_s   = 1'b0;
               dn_nx_s   = 1'b0;
               ac_nx_s   = 1'b0;
               pe_nx_s   = 1'b0;
            end else if (tenta && (state_r == ESPERA)) begin
               x_nx_s = palpite;
            end else begin
               x_nx_s = x_r;
            end
         end
         COMPARA: begin
            tent_nx_s = tent_inc_s;
            if (igual) begin
               ac_nx_s = 1'b1;
               dm_nx_s = 1'b0;
               dn_nx_s = 1'b0;
            end else begin
               dm_nx_s = maior;
               dn_nx_s = menor;
               pe_nx_s = limit_hit_s;
            end
         end
         default: begin
            x_nx_s = x_r;
         end
      endcase
   end

   // Datapath and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r    <= 4'd0;
         y_r    <= 4'd0;
         tent_r <= 4'd0;
         dm_r   <= 1'b0;
         dn_r   <= 1'b0;
         ac_r   <= 1'b0;
         pe_r   <= 1'b0;
      end else begin
         x_r    <= x_nx_s;
         y_r    <= y_nx_s;
         tent_r <= tent_nx_s;
         dm_r   <= dm_nx_s;
         dn_r   <= dn_nx_s;
         ac_r   <= ac_nx_s;
         pe_r   <= pe_nx_s;
      end
   end

   assign X          = x_r;
   assign Y          = y_r;
   assign tentativas = tent_r;
   assign dica_maior = dm_r;
   assign dica_menor = dn_r;
   assign acertou    = ac_r;
   assign perdeu     = pe_r;
   assign estado     = state_r;

endmodule

// File: tb/tb_adivinha_4bits.sv
// Scoreboard bench for adivinha_4bits: attempts queue their expected outcome, a negedge monitor checks it.
module tb_adivinha_4bits;

`ifdef ADIVINHA_LIMITE_EN
   localparam int MT = 3;
`else
   localparam int MT = 7;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       carrega = 1'b0;
   logic       tenta = 1'b0;
   logic [3:0] segredo = 4'd0;
   logic [3:0] palpite = 4'd0;
   logic [3:0] X, Y, tentativas;
   logic       igual, maior, menor;
   logic       dica_maior, dica_menor, acertou, perdeu;
   logic [1:0] estado;

   typedef struct packed {
      logic [1:0] est;
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] t;
      logic       dm;
      logic       dn;
      logic       ac;
      logic       pe;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic cmp_seen = 1'b0;
   int   attempt_no = 0;

   adivinha_4bits #(.MAX_TENT(MT)) dut (
      .clk(clk), .rst_n(rst_n), .carrega(carrega), .segredo(segredo),
      .tenta(tenta), .palpite(palpite), .X(X), .Y(Y),
      .igual(igual), .maior(maior), .menor(menor),
      .dica_maior(dica_maior), .dica_menor(dica_menor),
      .acertou(acertou), .perdeu(perdeu),
      .tentativas(tentativas), .estado(estado)
   );

   // External magnitude comparator
   assign igual = (X == Y);
   assign maior = (X > Y);
   assign menor = (X < Y);

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [1:0] e, input logic [3:0] x, input logic [3:0] y,
                               input logic [3:0] t, input logic dm, input logic dn,
                               input logic ac, input logic pe);
      obs_t o;
      o.est = e; o.x = x; o.y = y; o.t = t; o.dm = dm; o.dn = dn; o.ac = ac; o.pe = pe;
      return o;
   endfunction

   task automatic chk(input string name, input obs_t e);
      obs_t a;
      a = mk(estado, X, Y, tentativas, dica_maior, dica_menor, acertou, perdeu);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got est=%0d X=%0d Y=%0d t=%0d dm=%0b dn=%0b ac=%0b pe=%0b, required est=%0d X=%0d Y=%0d t=%0d dm=%0b dn=%0b ac=%0b pe=%0b",
                  name, a.est, a.x, a.y, a.t, a.dm, a.dn, a.ac, a.pe,
                  e.est, e.x, e.y, e.t, e.dm, e.dn, e.ac, e.pe);
      end
   endtask

   // Monitor: the cycle after COMPARA carries an attempt result
   always @(negedge clk) begin
      if (!rst_n) begin
         cmp_seen = 1'b0;
      end else begin
         if (cmp_seen) begin
            attempt_no++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_attempt #%0d: got result, required none queued", attempt_no);
            end else begin
               chk($sformatf("attempt_%0d", attempt_no), exp_q.pop_front());
            end
         end
         cmp_seen = (estado == 2'b10);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] s);
      carrega = 1'b1;
      segredo = s;
      tick();
      carrega = 1'b0;
   endtask

   task automatic guess(input logic [3:0] p, input obs_t e);
      exp_q.push_back(e);
      tenta = 1'b1;
      palpite = p;
      tick();
      tenta = 1'b0;
      tick();
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 chk("reset", mk(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      #9 rst_n = 1'b1;
      tick();

      tenta = 1'b1; palpite = 4'd5;
      tick();
      tenta = 1'b0;
      chk("ocioso_ignores_tenta", mk(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      load(4'd9);
      chk("load_9", mk(2'd1, 4'd0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      guess(4'd12, mk(2'd1, 4'd12, 4'd9, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
      guess(4'd5,  mk(2'd1, 4'd5,  4'd9, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));
      guess(4'd9,  mk(2'd3, 4'd9,  4'd9, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0));

      tenta = 1'b1; palpite = 4'd2;
      tick(); tick();
      tenta = 1'b0;
      chk("fim_ignores_tenta", mk(2'd3, 4'd9, 4'd9, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0));

      load(4'd7);
      chk("restart_from_fim", mk(2'd1, 4'd9, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      guess(4'd1, mk(2'd1, 4'd1, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
      guess(4'd2, mk(2'd1, 4'd2, 4'd7, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0));

      carrega = 1'b1; tenta = 1'b1; segredo = 4'd4; palpite = 4'd13;
      tick();
      carrega = 1'b0; tenta = 1'b0;
      chk("carrega_beats_tenta", mk(2'd1, 4'd2, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      chk("carrega_beats_tenta_hold", mk(2'd1, 4'd2, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Reset lands while the guess is in COMPARA
      tenta = 1'b1; palpite = 4'd3;
      tick();
      tenta = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("async_reset_in_compara", mk(2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      #4 rst_n = 1'b1;
      tick();

`ifdef ADIVINHA_LIMITE_EN
      load(4'd0);
      guess(4'd1, mk(2'd1, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
      guess(4'd2, mk(2'd1, 4'd2, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
      guess(4'd3, mk(2'd3, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1));
      tenta = 1'b1; palpite = 4'd0;
      tick(); tick();
      tenta = 1'b0;
      chk("fim_after_loss_holds", mk(2'd3, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1));
`else
      load(4'd15);
      for (int i = 0; i < 20; i++) begin
         guess(4'd0, mk(2'd1, 4'd0, 4'd15, (i >= 14) ? 4'd15 : 4'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0));
      end
      guess(4'd15, mk(2'd3, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0));
`endif

      tick(); tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_attempts: got %0d results outstanding, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adivinha_4bits.md
# adivinha_4bits

Sequential guessing-game controller that sits around the 4-bit magnitude comparator. It registers a 4-bit secret and successive 4-bit guesses, and drives them onto the comparator operands. It then consumes the comparator's `igual`/`maior`/`menor` flags to produce hints, count attempts and declare win or loss. It is the control stage both upstream and downstream of the comparator in the lab's game top level.

## Interface
- `MAX_TENT`, default 7: attempts allowed before loss. Legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `carrega`  in  1  loads `segredo` and restarts the game. Sampled in OCIOSO, ESPERA and FIM.
- `segredo`  in  4  secret value.
- `tenta`  in  1  submits `palpite`. Sampled only in ESPERA.
- `palpite`  in  4  guess value.
- `X`  out  4  registered guess, to comparator input X.
- `Y`  out  4  registered secret, to comparator input Y.
- `igual`, `maior`, `menor`  in  1 each  comparator results for X vs Y.
- `dica_maior`  out  1  last guess was greater than the secret.
- `dica_menor`  out  1  last guess was less than the secret.
- `acertou`  out  1  game won.
- `perdeu`  out  1  game lost.
- `tentativas`  out  4  attempts consumed.
- `estado`  out  2  FSM state: OCIOSO=00, ESPERA=01, COMPARA=10, FIM=11.

## Operation
- Reset:
  - `estado`=OCIOSO.
  - `X`=0, `Y`=0, `tentativas`=0.
  - `dica_maior`, `dica_menor`, `acertou`, `perdeu` all 0.
  - Reset is asynchronous and valid in any state, including mid-COMPARA.
- OCIOSO:
  - `carrega`=1: `Y`<=`segredo`, `tentativas`<=0, all four flags <=0, go to ESPERA.
  - `tenta` is ignored.
- ESPERA:
  - `carrega`=1: same reload as in OCIOSO; stay in ESPERA. `carrega` wins over a simultaneous `tenta`, and `X` is left unchanged.
  - Otherwise `tenta`=1: `X`<=`palpite`, go to COMPARA.
- COMPARA lasts exactly one cycle. `carrega` and `tenta` are ignored. On the edge:
  - `tentativas`<=`tentativas`+1.
  - `igual`=1: `acertou`<=1, both hints <=0, go to FIM. `igual` has priority over `maior`/`menor`.
  - Else: `dica_maior`<=`maior`, `dica_menor`<=`menor`.
  - Else, if `tentativas`+1 == `MAX_TENT`: `perdeu`<=1, go to FIM.
  - Else: go to ESPERA.
  - If none of `igual`/`maior`/`menor` is asserted, the attempt still counts and both hints are 0.
- FIM:
  - All outputs hold.
  - `tenta` is ignored.
  - `carrega`=1 restarts exactly as from OCIOSO.
- `acertou` and `perdeu` are never both 1.

## Timing
- `tenta` is sampled at edge k in ESPERA:
  - `X` is valid after edge k.
  - The comparator settles combinationally during cycle k..k+1.
  - Flags and `tentativas` update after edge k+1.
  - Latency is 2 edges.
- `tenta` held high yields one attempt every 2 cycles: ESPERA→COMPARA→ESPERA.
- `carrega` takes effect 1 edge after sampling.
- `Y` is stable from load until the next `carrega` or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ADIVINHA_LIMITE_EN` defined:
  - The attempt limit is active as described above.
- Not defined:
  - `MAX_TENT` is unused and `perdeu` is tied to 0.
  - COMPARA returns to ESPERA on any non-`igual` result.
  - `tentativas` saturates at 15; it does not wrap.

## Test plan
- Assert `rst_n`=0 during COMPARA (after `tenta`) -> `estado`=00, `X`=`Y`=0, `tentativas`=0, all flags 0 immediately, without waiting for a clock edge.
- Load `segredo`=9. Guess 12 -> `dica_maior`=1, `tentativas`=1. Guess 5 -> `dica_menor`=1, `tentativas`=2. Guess 9 -> `acertou`=1, `tentativas`=3, `estado`=11, flags valid 2 edges after `tenta` sampling.
- With `ADIVINHA_LIMITE_EN` and `MAX_TENT`=3, `segredo`=0, guesses 1, 2, 3 -> `perdeu`=1 and `tentativas`=3 after the third. A further `tenta` leaves all outputs unchanged.
- In ESPERA with `tentativas`=2, assert `carrega`=1 and `tenta`=1 in the same cycle with `segredo`=4 -> `Y`=4, `tentativas`=0, `X` unchanged, `estado`=01.
- Without `ADIVINHA_LIMITE_EN`, `segredo`=15, 20 guesses of 0 -> `tentativas` stops at 15, `perdeu`=0, `dica_menor`=1. A guess of 15 then gives `acertou`=1.
- In FIM after a win, `carrega`=1 with `segredo`=7 -> `acertou`=0, `tentativas`=0, `Y`=7, `estado`=01.
